// File: rtl/adxl362_sample_assembler.sv
// Rebuilds signed 12-bit X/Y/Z samples from an ADXL362 burst-read MISO byte stream,
// optionally box-car averages them, and presents results on a valid/ready output.
module adxl362_sample_assembler #(
    parameter int SKIP_BYTES = 2,
    parameter int AVG_LOG2   = 0
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [7:0]  byteIn,
    input  logic        byteValidIn,
    input  logic        frameStartIn,
    input  logic        frameEndIn,
    output logic [15:0] sampleXOut,
    output logic [15:0] sampleYOut,
    output logic [15:0] sampleZOut,
    output logic        sampleValidOut,
    input  logic        sampleReadyIn,
    output logic        frameErrOut,
    output logic [7:0]  overrunCountOut
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HEADER = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] TAIL   = 2'd3;

    localparam logic [1:0]    START_STATE = (SKIP_BYTES == 0) ? DATA : HEADER;
    localparam logic [7:0]    SKIP_LAST   = 8'(SKIP_BYTES - 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'((1 << AVG_LOG2) - 1);

    logic [1:0]    state_reg, state_next;
    logic [7:0]    hdr_cnt_reg, hdr_cnt_next;
    logic [2:0]    byte_idx_reg, byte_idx_next;
    logic [7:0]    bytes_reg [6];
    logic [7:0]    bytes_next [6];
    logic          commit;
    logic          err_next;
    logic          err_reg;
    logic [CW-1:0] frame_cnt_reg;
    logic          frame_last;
    logic          result_pend_reg;
    logic [15:0]   sample_reg [3];
    logic          valid_reg;
    logic [7:0]    overrun_reg;
    logic [15:0]   result_w [3];

    // Events are resolved in a fixed order: byte, then end, then start.
    always_comb begin
        state_next    = state_reg;
        hdr_cnt_next  = hdr_cnt_reg;
        byte_idx_next = byte_idx_reg;
        commit        = 1'b0;
        err_next      = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bytes_next[k] = bytes_reg[k];
        end

        if (byteValidIn && !frameStartIn) begin
            case (state_reg)
                HEADER: begin
                    if (hdr_cnt_reg == SKIP_LAST) begin
                        state_next    = DATA;
                        byte_idx_next = 3'd0;
                    end else begin
                        hdr_cnt_next = hdr_cnt_reg + 8'd1;
                    end
                end
                DATA: begin
                    for (int k = 0; k < 6; k++) begin
                        if (byte_idx_reg == 3'(k)) begin
                            bytes_next[k] = byteIn;
                        end
                    end
                    if (byte_idx_reg == 3'd5) begin
                        state_next = TAIL;
                    end else begin
                        byte_idx_next = byte_idx_reg + 3'd1;
                    end
                end
                default: ;
            endcase
        end

        if (frameEndIn) begin
            if (state_next == TAIL) begin
                commit = 1'b1;
            end else if (state_next != IDLE) begin
                err_next = 1'b1;
            end
            state_next = IDLE;
        end

        // A start that lands on an already-closed frame is clean; otherwise it aborts one.
        if (frameStartIn) begin
            if (state_next != IDLE) begin
                err_next = 1'b1;
            end
            state_next    = START_STATE;
            hdr_cnt_next  = 8'd0;
            byte_idx_next = 3'd0;
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_reg    <= IDLE;
            hdr_cnt_reg  <= 8'd0;
            byte_idx_reg <= 3'd0;
            err_reg      <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                bytes_reg[k] <= 8'd0;
            end
        end else begin
            state_reg    <= state_next;
            hdr_cnt_reg  <= hdr_cnt_next;
            byte_idx_reg <= byte_idx_next;
            err_reg      <= err_next;
            for (int k = 0; k < 6; k++) begin
                bytes_reg[k] <= bytes_next[k];
            end
        end
    end

    assign frame_last = (frame_cnt_reg == CNT_LAST);

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            frame_cnt_reg   <= '0;
            result_pend_reg <= 1'b0;
        end else begin
            result_pend_reg <= commit && frame_last;
            if (commit) begin
                frame_cnt_reg <= frame_last ? '0 : frame_cnt_reg + 1'b1;
            end
        end
    end

    // Per-axis sample rebuild and accumulation; bytes_next lets the 6th byte commit with the end.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            logic signed [11:0]   axis_val;
            logic signed [AW-1:0] acc_sum;
            logic signed [AW-1:0] acc_reg;
            logic [15:0]          result_reg;

            assign axis_val = {bytes_next[2*gi+1][3:0], bytes_next[2*gi]};
            assign acc_sum  = acc_reg + AW'(axis_val);
            assign result_w[gi] = result_reg;

            always_ff @(posedge clkIn or negedge rstIn) begin
                if (!rstIn) begin
                    acc_reg    <= '0;
                    result_reg <= 16'd0;
                end else if (commit) begin
                    if (frame_last) begin
                        result_reg <= 16'(acc_sum >>> AVG_LOG2);
                        acc_reg    <= '0;
                    end else begin
                        acc_reg <= acc_sum;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 8'd0;
            for (int k = 0; k < 3; k++) begin
                sample_reg[k] <= 16'd0;
            end
        end else if (result_pend_reg) begin
            if (!valid_reg || sampleReadyIn) begin
                valid_reg <= 1'b1;
                for (int k = 0; k < 3; k++) begin
                    sample_reg[k] <= result_w[k];
                end
            end else if (overrun_reg != 8'hFF) begin
                overrun_reg <= overrun_reg + 8'd1;
            end
        end else if (valid_reg && sampleReadyIn) begin
            valid_reg <= 1'b0;
        end
    end

    assign sampleXOut      = sample_reg[0];
    assign sampleYOut      = sample_reg[1];
    assign sampleZOut      = sample_reg[2];
    assign sampleValidOut  = valid_reg;
    assign frameErrOut     = err_reg;
    assign overrunCountOut = overrun_reg;

endmodule
